mod_n_updown_counter: RTL and testbench

- Parametrised modulo-N up/down counter.
- Generalises the fixed MOD12 counter with configurable width, modulus and reset value.
- Adds a per-cycle step size, wrap or saturate mode, a terminal-count carry for cascading, and error flags for illegal load or step values.
- Sits behind the same style of interface: write side is load/updown/d_in/rst, read side is d_out. Directly reusable by the existing driver and monitor structure.

---
 rtl/mod_n_updown_counter.sv | 146 ++++++++++++++
 tb/tb_mod_n_updown_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_updown_counter.sv
// ---------------------------------------------------------------------------
// mod_n_updown_counter
//
// Parametrised modulo-N up/down counter with a programmable step per enabled
// cycle, a wrap or saturate boundary mode, a combinational terminal count for
// cascading, and one-cycle error pulses for illegal load or step values.
//
// Parameters
//   WIDTH     : counter/data width in bits
//   MODULUS   : count range is 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   RESET_VAL : d_out value after reset (< MODULUS)
//
// Ports
//   clock    in   sole clock, all state changes on posedge
//   rst      in   synchronous active-high reset
//   en       in   count enable
//   load     in   parallel load request (beats en)
//   updown   in   1 = count up, 0 = count down
//   mode     in   0 = wrap at the boundary, 1 = saturate
//   step     in   magnitude added/subtracted per enabled cycle
//   d_in     in   load value
//   d_out    out  registered count
//   tc       out  combinational terminal count / cascade carry
//   wrap     out  registered pulse: count crossed the modulus boundary
//   sat      out  registered pulse: saturate mode clipped a move
//   load_err out  registered pulse: load value >= MODULUS was rejected
//   step_err out  registered pulse: step value >= MODULUS was rejected
// ---------------------------------------------------------------------------
module mod_n_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 12,
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             updown,
    input  logic             mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             tc,
    output logic             wrap,
    output logic             sat,
    output logic             load_err,
    output logic             step_err
);

    // Reject illegal parameter combinations at elaboration time.
    if (WIDTH < 1 || WIDTH > 30 || MODULUS < 2 || MODULUS > 2**WIDTH ||
        RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_check
        $fatal(1, "mod_n_updown_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end

    // MODULUS may equal 2**WIDTH, so it is only representable in WIDTH+1 bits.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   din_x;
    logic [WIDTH:0]   sum;

    logic [WIDTH-1:0] next_cnt;
    logic             next_wrap;
    logic             next_sat;
    logic             next_load_err;
    logic             next_step_err;

    // Widened operands: comparisons against MOD_W and the up-count sum must
    // not lose the carry bit.
    always_comb begin
        cnt_x  = {1'b0, d_out};
        step_x = {1'b0, step};
        din_x  = {1'b0, d_in};
        sum    = cnt_x + step_x;
    end

    always_comb begin
        next_cnt      = d_out;
        next_wrap     = 1'b0;
        next_sat      = 1'b0;
        next_load_err = 1'b0;
        next_step_err = 1'b0;

        if (load) begin
            if (din_x < MOD_W) begin
                next_cnt = d_in;
            end else begin
                next_load_err = 1'b1;
            end
        end else if (en) begin
            if (step_x >= MOD_W) begin
                next_step_err = 1'b1;
            end else if (step == '0) begin
                next_cnt = d_out;
            end else if (updown) begin
                if (sum < MOD_W) begin
                    next_cnt = sum[WIDTH-1:0];
                end else if (!mode) begin
                    next_cnt  = WIDTH'(sum - MOD_W);
                    next_wrap = 1'b1;
                end else begin
                    next_cnt = MAX_V;
                    next_sat = 1'b1;
                end
            end else begin
                if (step <= d_out) begin
                    next_cnt = d_out - step;
                end else if (!mode) begin
                    // d_out + MODULUS - step fits in WIDTH+1 bits and the
                    // result is < MODULUS because step > d_out.
                    next_cnt  = WIDTH'(cnt_x + MOD_W - step_x);
                    next_wrap = 1'b1;
                end else begin
                    next_cnt = '0;
                    next_sat = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            d_out    <= RESET_V;
            wrap     <= 1'b0;
            sat      <= 1'b0;
            load_err <= 1'b0;
            step_err <= 1'b0;
        end else begin
            d_out    <= next_cnt;
            wrap     <= next_wrap;
            sat      <= next_sat;
            load_err <= next_load_err;
            step_err <= next_step_err;
        end
    end

    // Carry for a higher-order stage: asserted when this stage is about to
    // roll over in the current direction.
    assign tc = en & ~load & ~rst &
                ((updown & (d_out == MAX_V)) | (~updown & (d_out == '0)));

endmodule

// File: tb/tb_mod_n_updown_counter.sv
module tb_mod_n_updown_counter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default instance: WIDTH=4, MODULUS=12, RESET_VAL=0
    logic       a_rst, a_en, a_load, a_updown, a_mode;
    logic [3:0] a_step, a_d_in, a_d_out;
    logic       a_tc, a_wrap, a_sat, a_load_err, a_step_err;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(12), .RESET_VAL(0)) dut_a (
        .clock(clock), .rst(a_rst), .en(a_en), .load(a_load), .updown(a_updown),
        .mode(a_mode), .step(a_step), .d_in(a_d_in), .d_out(a_d_out), .tc(a_tc),
        .wrap(a_wrap), .sat(a_sat), .load_err(a_load_err), .step_err(a_step_err)
    );

    // Wide instance: WIDTH=8, MODULUS=200, RESET_VAL=199
    logic       b_rst, b_en, b_load, b_updown, b_mode;
    logic [7:0] b_step, b_d_in, b_d_out;
    logic       b_tc, b_wrap, b_sat, b_load_err, b_step_err;

    mod_n_updown_counter #(.WIDTH(8), .MODULUS(200), .RESET_VAL(199)) dut_b (
        .clock(clock), .rst(b_rst), .en(b_en), .load(b_load), .updown(b_updown),
        .mode(b_mode), .step(b_step), .d_in(b_d_in), .d_out(b_d_out), .tc(b_tc),
        .wrap(b_wrap), .sat(b_sat), .load_err(b_load_err), .step_err(b_step_err)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic void ref_model(
        input int m, input int rv, input int cnt,
        input bit r, input bit e, input bit l, input bit u, input bit mo,
        input int st, input int di,
        output int ncnt, output bit w, output bit s, output bit le, output bit se);
        int target;
        ncnt = cnt; w = 0; s = 0; le = 0; se = 0;
        if (r) begin
            ncnt = rv;
        end else if (l) begin
            if (di < m) ncnt = di;
            else le = 1;
        end else if (e) begin
            if (st >= m) begin
                se = 1;
            end else if (st != 0) begin
                target = u ? cnt + st : cnt - st;
                if (target >= 0 && target < m) begin
                    ncnt = target;
                end else if (!mo) begin
                    ncnt = ((target % m) + m) % m;
                    w = 1;
                end else begin
                    ncnt = (target < 0) ? 0 : m - 1;
                    s = 1;
                end
            end
        end
    endfunction

    typedef struct {
        string name;
        bit    rst, en, load, updown, mode;
        int    step, din;
        bit    exp_tc;     // tc with these inputs, before the edge
        int    exp_out;    // d_out after the edge
        int    exp_flags;  // {wrap, sat, load_err, step_err} after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input bit r, input bit e, input bit l,
                                input bit u, input bit m, input int st, input int di,
                                input bit tc, input int q, input int fl);
        vec_t v;
        v.name = n; v.rst = r; v.en = e; v.load = l; v.updown = u; v.mode = m;
        v.step = st; v.din = di; v.exp_tc = tc; v.exp_out = q; v.exp_flags = fl;
        return v;
    endfunction

    task automatic drive_a(input bit r, input bit e, input bit l, input bit u,
                           input bit m, input int st, input int di);
        a_rst = r; a_en = e; a_load = l; a_updown = u; a_mode = m;
        a_step = 4'(st); a_d_in = 4'(di);
    endtask

    task automatic drive_b(input bit r, input bit e, input bit l, input bit u,
                           input bit m, input int st, input int di);
        b_rst = r; b_en = e; b_load = l; b_updown = u; b_mode = m;
        b_step = 8'(st); b_d_in = 8'(di);
    endtask

    task automatic apply_a(input vec_t v);
        drive_a(v.rst, v.en, v.load, v.updown, v.mode, v.step, v.din);
        #1;
        chk({v.name, ".tc"}, 32'(a_tc), 32'(v.exp_tc));
        @(posedge clock); #1;
        chk({v.name, ".d_out"}, 32'(a_d_out), 32'(v.exp_out));
        chk({v.name, ".flags"}, 32'({a_wrap, a_sat, a_load_err, a_step_err}), 32'(v.exp_flags));
    endtask

    task automatic apply_b(input string name, input bit r, input bit e, input bit l,
                           input bit u, input bit m, input int st, input int di,
                           input bit etc, input int q, input int fl);
        drive_b(r, e, l, u, m, st, di);
        #1;
        chk({name, ".tc"}, 32'(b_tc), 32'(etc));
        @(posedge clock); #1;
        chk({name, ".d_out"}, 32'(b_d_out), 32'(q));
        chk({name, ".flags"}, 32'({b_wrap, b_sat, b_load_err, b_step_err}), 32'(fl));
    endtask

    task automatic rand_a(input int n);
        int m_cnt = 0;
        int st, di, ncnt;
        bit r, e, l, u, mo, w, s, le, se, etc;
        for (int i = 0; i < n; i++) begin
            r  = (i == 0) || ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 4) != 0);
            u  = 1'($urandom_range(0, 1));
            mo = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            di = int'($urandom_range(0, 15));
            drive_a(r, e, l, u, mo, st, di);
            #1;
            etc = e && !l && !r && ((u && m_cnt == 11) || (!u && m_cnt == 0));
            chk("rand_a.tc", 32'(a_tc), 32'(etc));
            @(posedge clock); #1;
            ref_model(12, 0, m_cnt, r, e, l, u, mo, st, di, ncnt, w, s, le, se);
            m_cnt = ncnt;
            chk("rand_a.state", 32'({a_d_out, a_wrap, a_sat, a_load_err, a_step_err}),
                32'({4'(ncnt), w, s, le, se}));
        end
    endtask

    task automatic rand_b(input int n);
        int m_cnt = 199;
        int st, di, ncnt;
        bit r, e, l, u, mo, w, s, le, se, etc;
        for (int i = 0; i < n; i++) begin
            r  = (i == 0) || ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 4) != 0);
            u  = 1'($urandom_range(0, 1));
            mo = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 60));
            di = ($urandom_range(0, 3) == 0) ? int'($urandom_range(180, 255)) : int'($urandom_range(0, 199));
            drive_b(r, e, l, u, mo, st, di);
            #1;
            etc = e && !l && !r && ((u && m_cnt == 199) || (!u && m_cnt == 0));
            chk("rand_b.tc", 32'(b_tc), 32'(etc));
            @(posedge clock); #1;
            ref_model(200, 199, m_cnt, r, e, l, u, mo, st, di, ncnt, w, s, le, se);
            m_cnt = ncnt;
            chk("rand_b.state", 32'({b_d_out, b_wrap, b_sat, b_load_err, b_step_err}),
                32'({8'(ncnt), w, s, le, se}));
        end
    endtask

    initial begin
        drive_a(1, 0, 0, 0, 0, 0, 0);
        drive_b(1, 0, 0, 0, 0, 0, 0);

        //                 name        rst en ld ud md stp din  tc out  flags{w,s,le,se}
        vecs.push_back(mk("rst1",       1, 0, 0, 0, 0,  0,  0,  0,  0, 4'b0000));
        vecs.push_back(mk("rst2",       1, 0, 0, 0, 0,  0,  0,  0,  0, 4'b0000));
        vecs.push_back(mk("idle",       0, 0, 0, 0, 0,  0,  0,  0,  0, 4'b0000));
        vecs.push_back(mk("ld10",       0, 0, 1, 0, 0,  0, 10,  0, 10, 4'b0000));
        vecs.push_back(mk("up_a",       0, 1, 0, 1, 0,  1,  0,  0, 11, 4'b0000));
        vecs.push_back(mk("up_wrap",    0, 1, 0, 1, 0,  1,  0,  1,  0, 4'b1000));
        vecs.push_back(mk("up_b",       0, 1, 0, 1, 0,  1,  0,  0,  1, 4'b0000));
        vecs.push_back(mk("ld2",        0, 0, 1, 0, 0,  0,  2,  0,  2, 4'b0000));
        vecs.push_back(mk("dn5_wrap",   0, 1, 0, 0, 0,  5,  0,  0,  9, 4'b1000));
        vecs.push_back(mk("dn5",        0, 1, 0, 0, 0,  5,  0,  0,  4, 4'b0000));
        vecs.push_back(mk("ld10s",      0, 0, 1, 0, 1,  0, 10,  0, 10, 4'b0000));
        vecs.push_back(mk("sat_up1",    0, 1, 0, 1, 1,  3,  0,  0, 11, 4'b0100));
        vecs.push_back(mk("sat_up2",    0, 1, 0, 1, 1,  3,  0,  1, 11, 4'b0100));
        vecs.push_back(mk("sat_dn1",    0, 1, 0, 0, 1, 11,  0,  0,  0, 4'b0000));
        vecs.push_back(mk("sat_dn2",    0, 1, 0, 0, 1, 11,  0,  1,  0, 4'b0100));
        vecs.push_back(mk("ld7",        0, 0, 1, 0, 0,  0,  7,  0,  7, 4'b0000));
        vecs.push_back(mk("ld_bad",     0, 1, 1, 1, 0,  1, 13,  0,  7, 4'b0010));
        vecs.push_back(mk("step_bad",   0, 1, 0, 1, 0, 12,  0,  0,  7, 4'b0001));
        vecs.push_back(mk("rst_ovr",    1, 1, 1, 1, 0,  1,  5,  0,  0, 4'b0000));
        vecs.push_back(mk("step0_up",   0, 1, 0, 1, 0,  0,  0,  0,  0, 4'b0000));
        vecs.push_back(mk("step0_dn",   0, 1, 0, 0, 1,  0,  0,  1,  0, 4'b0000));
        vecs.push_back(mk("ld11",       0, 0, 1, 0, 0,  0, 11,  0, 11, 4'b0000));
        vecs.push_back(mk("up11_wrap",  0, 1, 0, 1, 0, 11,  0,  1, 10, 4'b1000));
        vecs.push_back(mk("dn11_wrap",  0, 1, 0, 0, 0, 11,  0,  0, 11, 4'b1000));
        vecs.push_back(mk("ld_max",     0, 0, 1, 0, 0,  0, 15,  0, 11, 4'b0010));

        foreach (vecs[i]) apply_a(vecs[i]);

        // Wide instance, hand-written corner sequence
        apply_b("b_rst1",    1, 0, 0, 0, 0,   0,   0, 0, 199, 4'b0000);
        apply_b("b_rst2",    1, 0, 0, 0, 0,   0,   0, 0, 199, 4'b0000);
        apply_b("b_up_wrap", 0, 1, 0, 1, 0,   1,   0, 1,   0, 4'b1000);
        apply_b("b_dn_wrap", 0, 1, 0, 0, 0,   1,   0, 1, 199, 4'b1000);
        apply_b("b_ld250",   0, 1, 1, 1, 0,   1, 250, 0, 199, 4'b0010);
        apply_b("b_ld199",   0, 0, 1, 0, 0,   0, 199, 0, 199, 4'b0000);
        apply_b("b_ld200",   0, 0, 1, 0, 0,   0, 200, 0, 199, 4'b0010);
        apply_b("b_step200", 0, 1, 0, 0, 1, 200,   0, 0, 199, 4'b0001);
        apply_b("b_step199", 0, 1, 0, 0, 1, 199,   0, 0,   0, 4'b0000);
        apply_b("b_sat_up",  0, 1, 0, 1, 1, 199,   0, 0, 199, 4'b0000);
        apply_b("b_sat_up2", 0, 1, 0, 1, 1,   1,   0, 1, 199, 4'b0100);

        rand_a(1500);
        rand_b(1000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
